// File: rtl/ds1620_pkg.sv
// DS1620 responder shared definitions.
// Command bytes, FSM state codes and the temperature word width.
package ds1620_pkg;

  localparam int TEMP_W = 9;

  localparam logic [7:0] CMD_READ_TEMP = 8'hAA;
  localparam logic [7:0] CMD_START     = 8'hEE;
  localparam logic [7:0] CMD_STOP      = 8'h22;
  localparam logic [7:0] CMD_WR_CFG    = 8'h0C;
  localparam logic [7:0] CMD_RD_CFG    = 8'hAC;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_TX   = 3'd2;
  localparam state_t ST_RX   = 3'd3;
  localparam state_t ST_HOLD = 3'd4;

endpackage

// File: rtl/ds1620_sync_edge.sv
// 3-flop synchronizer with rise/fall strobes.
// Ports: clk, rst_n (async low), d (async in), rise, fall (1-cycle).
module ds1620_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/ds1620_responder.sv
// DS1620 3-wire device-side responder: command decode, temp/config
// readout, config write, conversion flag. Ports: CLK_IN, CLR_N,
// SCLK, RST_IN, DQ_IN, TEMP_IN -> DQ_OUT, DQ_OE, CONV_ACTIVE,
// CONFIG, CMD_ERR. Macro DS1620_CONFIG_EN builds config r/w.
module ds1620_responder
  import ds1620_pkg::*;
#(
  parameter int          DIV_MIN   = 8,
  parameter logic [7:0]  CFG_RESET = 8'h02
) (
  input  logic              CLK_IN,
  input  logic              CLR_N,
  input  logic              SCLK,
  input  logic              RST_IN,
  input  logic              DQ_IN,
  input  logic [TEMP_W-1:0] TEMP_IN,
  output logic              DQ_OUT,
  output logic              DQ_OE,
  output logic              CONV_ACTIVE,
  output logic [7:0]        CONFIG,
  output logic              CMD_ERR
);

  localparam logic [7:0] PH_MIN = 8'(DIV_MIN / 2 - 2);

  logic sclk_rise;
  logic sclk_fall;

  ds1620_sync_edge u_sclk (
    .clk  (CLK_IN),
    .rst_n(CLR_N),
    .d    (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  logic rst_s1_q, rst_s2_q;
  logic dq_s1_q, dq_s2_q;

  always_ff @(posedge CLK_IN or negedge CLR_N) begin
    if (!CLR_N) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
      dq_s1_q  <= 1'b0;
      dq_s2_q  <= 1'b0;
    end else begin
      rst_s1_q <= RST_IN;
      rst_s2_q <= rst_s1_q;
      dq_s1_q  <= DQ_IN;
      dq_s2_q  <= dq_s1_q;
    end
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [TEMP_W-1:0] shift_q, shift_d;
  logic              dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              conv_q, conv_d;
  logic              err_q, err_d;
  logic [7:0]        cmd_nx;
`ifdef DS1620_CONFIG_EN
  logic [7:0]        cfg_q, cfg_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        data_nx;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    conv_d  = conv_q;
    err_d   = 1'b0;
    cmd_nx  = {dq_s2_q, cmd_q[7:1]};
`ifdef DS1620_CONFIG_EN
    cfg_d   = cfg_q;
    data_d  = data_q;
    data_nx = {dq_s2_q, data_q[7:1]};
`endif
    // RST_IN low overrides any same-cycle SCLK edge
    if (!rst_s2_q) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 4'd0;
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_d = cmd_nx;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              unique case (1'b1)
                (cmd_nx == CMD_READ_TEMP): begin
                  shift_d = TEMP_IN;
                  len_d   = 4'(TEMP_W);
                  state_d = ST_TX;
                end
`ifdef DS1620_CONFIG_EN
                (cmd_nx == CMD_RD_CFG): begin
                  shift_d = {1'b0, cfg_q};
                  len_d   = 4'd8;
                  state_d = ST_TX;
                end
                (cmd_nx == CMD_WR_CFG): begin
                  state_d = ST_RX;
                end
`endif
                (cmd_nx == CMD_START): begin
                  conv_d  = 1'b1;
                  state_d = ST_HOLD;
                end
                (cmd_nx == CMD_STOP): begin
                  conv_d  = 1'b0;
                  state_d = ST_HOLD;
                end
                default: begin
                  err_d   = 1'b1;
                  state_d = ST_HOLD;
                end
              endcase
            end
          end
        end
        ST_TX: begin
          if (sclk_fall && cnt_q != len_q) begin
            oe_d    = 1'b1;
            dout_d  = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
          end else if (sclk_rise && cnt_q == len_q) begin
            // master has sampled the last bit
            oe_d    = 1'b0;
            state_d = ST_HOLD;
          end
        end
`ifdef DS1620_CONFIG_EN
        ST_RX: begin
          if (sclk_rise) begin
            data_d = data_nx;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cfg_d   = data_nx;
              state_d = ST_HOLD;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_IN or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      len_q   <= 4'd0;
      cmd_q   <= 8'h00;
      shift_q <= '0;
      dout_q  <= 1'b0;
      oe_q    <= 1'b0;
      conv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      conv_q  <= conv_d;
      err_q   <= err_d;
    end
  end

`ifdef DS1620_CONFIG_EN
  always_ff @(posedge CLK_IN or negedge CLR_N) begin
    if (!CLR_N) begin
      cfg_q  <= CFG_RESET;
      data_q <= 8'h00;
    end else begin
      cfg_q  <= cfg_d;
      data_q <= data_d;
    end
  end

  assign CONFIG = cfg_q;
`else
  assign CONFIG = CFG_RESET;
`endif

  assign DQ_OUT      = dout_q;
  assign DQ_OE       = oe_q;
  assign CONV_ACTIVE = conv_q;
  assign CMD_ERR     = err_q;

  // cycles since the last synced SCLK edge, for the phase check
  logic [7:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (sclk_rise || sclk_fall) begin
      phase_d = 8'd0;
    end else if (phase_q != 8'hFF) begin
      phase_d = phase_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_IN or negedge CLR_N) begin
    if (!CLR_N) begin
      phase_q <= 8'hFF;
    end else begin
      phase_q <= phase_d;
    end
  end

  a_sclk_phase: assert property (
    @(posedge CLK_IN) disable iff (!CLR_N)
    (sclk_rise || sclk_fall) |-> (phase_q >= PH_MIN)
  );

endmodule

// File: tb/tb_ds1620_responder.sv
// Scoreboard bench for ds1620_responder: serial bits queued by
// stimulus, popped and compared by a monitor on each SCLK rise.
module tb_ds1620_responder;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       sclk;
  logic       rst_in;
  logic       dq_in;
  logic [8:0] temp_in;
  logic       dq_out;
  logic       dq_oe;
  logic       conv;
  logic [7:0] cfg;
  logic       cmd_err;

  always #5 clk = ~clk;

  ds1620_responder dut (
    .CLK_IN     (clk),
    .CLR_N      (clr_n),
    .SCLK       (sclk),
    .RST_IN     (rst_in),
    .DQ_IN      (dq_in),
    .TEMP_IN    (temp_in),
    .DQ_OUT     (dq_out),
    .DQ_OE      (dq_oe),
    .CONV_ACTIVE(conv),
    .CONFIG     (cfg),
    .CMD_ERR    (cmd_err)
  );

  int total  = 0;
  int passed = 0;
  bit exp_q[$];
  int err_pulses = 0;
  int err_len    = 0;

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // serial monitor: controller samples DQ on SCLK rise
  always @(posedge sclk) begin
    if (dq_oe === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL dq_drive: got unexpected bit %b expected none",
                 dq_out);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (dq_out === e) passed++;
        else $display("FAIL dq_bit: got %b expected %b", dq_out, e);
      end
    end
  end

  // CMD_ERR pulse width monitor
  always @(negedge clk) begin
    if (cmd_err === 1'b1) begin
      err_len++;
    end else if (err_len != 0) begin
      err_pulses++;
      total++;
      if (err_len == 1) passed++;
      else $display("FAIL err_width: got %0d expected 1", err_len);
      err_len = 0;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    sclk  = 1'b0;
    dq_in = b;
    wait_cyc(8);
    sclk  = 1'b1;
  endtask

  // returns right after the 8th rise
  task automatic send_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i != 7) wait_cyc(8);
    end
  endtask

  task automatic start_txn();
    rst_in = 1'b1;
    wait_cyc(8);
  endtask

  task automatic end_txn();
    wait_cyc(8);
    rst_in = 1'b0;
    wait_cyc(8);
  endtask

  task automatic read_bits(int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      wait_cyc(8);
      sclk = 1'b1;
      wait_cyc(8);
    end
  endtask

  task automatic push_bits(logic [8:0] w, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
  endtask

  task automatic read_temp(logic [8:0] t, logic [8:0] lsb_first);
    temp_in = t;
    start_txn();
    send_byte(8'hAA);
    push_bits(lsb_first, 9);
    wait_cyc(8);
    read_bits(1);
    temp_in = 9'h155;
    read_bits(8);
    check("temp_oe_release", 9'(dq_oe), 9'd0);
    check("temp_all_bits", 9'(exp_q.size()), 9'd0);
    end_txn();
  endtask

  int p0;

  initial begin
    clr_n   = 1'b0;
    sclk    = 1'b1;
    rst_in  = 1'b0;
    dq_in   = 1'b0;
    temp_in = 9'h000;
    wait_cyc(4);
    check("rst_oe", 9'(dq_oe), 9'd0);
    check("rst_out", 9'(dq_out), 9'd0);
    check("rst_cfg", 9'(cfg), 9'h002);
    check("rst_conv", 9'(conv), 9'd0);
    check("rst_err", 9'(cmd_err), 9'd0);
    clr_n = 1'b1;
    wait_cyc(8);

    // 25 C: bits 0,1,0,0,1,1,0,0,0
    read_temp(9'h032, 9'b000_110_010);
    // 17 C: bits 0,1,0,0,0,1,0,0,0
    read_temp(9'h022, 9'b000_100_010);

    start_txn();
    send_byte(8'hEE);
    wait_cyc(4);
    check("conv_start", 9'(conv), 9'd1);
    end_txn();
    check("conv_retained", 9'(conv), 9'd1);
    start_txn();
    send_byte(8'h22);
    wait_cyc(4);
    check("conv_stop", 9'(conv), 9'd0);
    check("conv_oe", 9'(dq_oe), 9'd0);
    end_txn();

    p0 = err_pulses;
    start_txn();
    send_byte(8'h0C);
    wait_cyc(8);
    send_byte(8'h0B);
    wait_cyc(4);
`ifdef DS1620_CONFIG_EN
    check("cfg_write", 9'(cfg), 9'h00B);
`endif
    end_txn();
    start_txn();
    send_byte(8'hAC);
`ifdef DS1620_CONFIG_EN
    // 0x0B LSB-first: 1,1,0,1,0,0,0,0
    push_bits(9'b0_0000_1011, 8);
`endif
    wait_cyc(8);
    read_bits(8);
    check("cfg_oe_release", 9'(dq_oe), 9'd0);
    check("cfg_all_bits", 9'(exp_q.size()), 9'd0);
    end_txn();
`ifndef DS1620_CONFIG_EN
    check("cfg_err_count", 9'(err_pulses - p0), 9'd2);
    check("cfg_const", 9'(cfg), 9'h002);
`endif

    // abort after 4 of 9 bits
    temp_in = 9'h032;
    start_txn();
    send_byte(8'hAA);
    push_bits(9'b000_110_010, 4);
    wait_cyc(8);
    read_bits(4);
    rst_in = 1'b0;
    wait_cyc(3);
    check("abort_oe", 9'(dq_oe), 9'd0);
    check("abort_bits", 9'(exp_q.size()), 9'd0);
    wait_cyc(8);
    read_temp(9'h022, 9'b000_100_010);

    p0 = err_pulses;
    start_txn();
    send_byte(8'h55);
    wait_cyc(3);
    check("bad_err_hi", 9'(cmd_err), 9'd1);
    wait_cyc(1);
    check("bad_err_lo", 9'(cmd_err), 9'd0);
    wait_cyc(4);
    read_bits(3);
    check("bad_oe", 9'(dq_oe), 9'd0);
    check("bad_conv", 9'(conv), 9'd0);
    check("bad_err_count", 9'(err_pulses - p0), 9'd1);
    end_txn();

    wait_cyc(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
